// File: rtl/user_input_irq_pkg.sv
// Shared register map and reset constants for the push-button / switch
// interrupt controller.
package user_input_irq_pkg;

    localparam logic [2:0] REG_LEVEL   = 3'd0;
    localparam logic [2:0] REG_MASK    = 3'd1;
    localparam logic [2:0] REG_PENDING = 3'd2;
    localparam logic [2:0] REG_RISE_EN = 3'd3;
    localparam logic [2:0] REG_FALL_EN = 3'd4;
    localparam logic [2:0] REG_EVCOUNT = 3'd5;

    // Full-width reset images; the top slices off the bits it implements.
    localparam logic [31:0] RISE_EN_RESET = 32'hFFFF_FFFF;
    localparam logic [31:0] FALL_EN_RESET = 32'h0000_0000;

    localparam logic [15:0] EVCOUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/user_input_irq_ctrl_debouncer.sv
// One-bit input conditioner: 2-flop synchroniser, stability counter and a
// post-reset settle window during which the output simply follows the input.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic debounced,
    output logic settled
);

    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int SETTLE_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_END = SETTLE_W'(DEBOUNCE_CYCLES);

    logic                meta_reg;
    logic                synced_reg;
    logic                deb_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [SETTLE_W-1:0] settle_reg;
    logic                settling;

    assign settling = (settle_reg != SETTLE_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg   <= 1'b0;
            synced_reg <= 1'b0;
            deb_reg    <= 1'b0;
            cnt_reg    <= '0;
            settle_reg <= '0;
        end else begin
            meta_reg   <= raw;
            synced_reg <= meta_reg;
            if (settling) begin
                // Accept whatever level is present at power-up without filtering.
                settle_reg <= settle_reg + 1'b1;
                deb_reg    <= synced_reg;
                cnt_reg    <= '0;
            end else if (synced_reg == deb_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                deb_reg <= synced_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign debounced = deb_reg;
    assign settled   = ~settling;

endmodule

// File: rtl/user_input_irq_ctrl.sv
// Avalon-MM interrupt controller for KEY/SW inputs: debounce, programmable
// edge capture into a W1C pending register, masked registered irq.
module user_input_irq_ctrl
    import user_input_irq_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 5,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys,
    input  logic [N_SW-1:0]   switches,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq
);

    localparam int N = N_KEYS + N_SW;

    logic [N-1:0]  in_raw;
    logic [N-1:0]  deb;
    logic [N-1:0]  settled;
    logic [N-1:0]  deb_q_reg;
    logic          capture_en_reg;
    logic [N-1:0]  mask_reg;
    logic [N-1:0]  pending_reg;
    logic [N-1:0]  rise_en_reg;
    logic [N-1:0]  fall_en_reg;
    logic [15:0]   evcount_reg;
    logic          irq_reg;
    logic [31:0]   readdata_reg;
    logic [N-1:0]  rise;
    logic [N-1:0]  fall;
    logic [N-1:0]  event_vec;
    logic [N-1:0]  w1c;
    logic [N-1:0]  wdata;
    logic [31:0]   read_value;
    logic          unused_wdata_bits;

    assign in_raw = {switches, ~keys};

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_deb
            input_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk      (clk),
                .reset    (reset),
                .raw      (in_raw[gi]),
                .debounced(deb[gi]),
                .settled  (settled[gi])
            );
        end
    endgenerate

    assign wdata             = avs_writedata[N-1:0];
    assign unused_wdata_bits = &{1'b0, avs_writedata[31:N]};

    assign rise      = deb & ~deb_q_reg;
    assign fall      = ~deb & deb_q_reg;
    // Capture is held off one cycle past settle so the last settle copy is not seen as an edge.
    assign event_vec = capture_en_reg ? ((rise & rise_en_reg) | (fall & fall_en_reg)) : '0;
    assign w1c       = (avs_write && avs_address == REG_PENDING) ? wdata : '0;

    always_comb begin
        read_value = '0;
        case (avs_address)
            REG_LEVEL:   read_value[N-1:0] = deb;
            REG_MASK:    read_value[N-1:0] = mask_reg;
            REG_PENDING: read_value[N-1:0] = pending_reg;
            REG_RISE_EN: read_value[N-1:0] = rise_en_reg;
            REG_FALL_EN: read_value[N-1:0] = fall_en_reg;
            REG_EVCOUNT: read_value[15:0]  = evcount_reg;
            default:     read_value        = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q_reg      <= '0;
            capture_en_reg <= 1'b0;
            mask_reg       <= '0;
            pending_reg    <= '0;
            rise_en_reg    <= RISE_EN_RESET[N-1:0];
            fall_en_reg    <= FALL_EN_RESET[N-1:0];
            evcount_reg    <= '0;
            irq_reg        <= 1'b0;
            readdata_reg   <= '0;
        end else begin
            deb_q_reg      <= deb;
            capture_en_reg <= &settled;
            pending_reg    <= (pending_reg & ~w1c) | event_vec;
            irq_reg        <= |(pending_reg & mask_reg);
            if (avs_read) begin
                readdata_reg <= read_value;
            end
            if (avs_write) begin
                case (avs_address)
                    REG_MASK:    mask_reg    <= wdata;
                    REG_RISE_EN: rise_en_reg <= wdata;
                    REG_FALL_EN: fall_en_reg <= wdata;
                    default:     ;
                endcase
            end
            if (avs_write && avs_address == REG_EVCOUNT) begin
                evcount_reg <= '0;
            end else if (|event_vec && evcount_reg != EVCOUNT_MAX) begin
                evcount_reg <= evcount_reg + 1'b1;
            end
        end
    end

    assign avs_readdata = readdata_reg;
    assign irq          = irq_reg;

endmodule
